// File: rtl/rvc_asap_pkg.sv
// rtl/rvc_asap_pkg.sv - shared types, defaults and flop macros for the rvc_asap VGA burst memory
`ifndef RVC_ASAP_PKG_SV
`define RVC_ASAP_PKG_SV

`define RVC_MSFF(q, d, clk) always_ff @(posedge clk) q <= d;
`define RVC_RST_MSFF(q, d, clk, rst_n, val) always_ff @(posedge clk) if (!(rst_n)) q <= val; else q <= d;

package rvc_asap_pkg;
  localparam int VGA_BURST_DATA_W     = 32;
  localparam int VGA_BURST_ADDR_W     = 12;
  localparam int VGA_BURST_FIFO_DEPTH = 4;
  localparam int VGA_BURST_LEN_W      = 8;
  localparam int SIZE_VGA_MEM         = (2 ** VGA_BURST_ADDR_W) * (VGA_BURST_DATA_W / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } t_vga_burst_state;
endpackage

`endif

// File: rtl/rvc_asap_vga_burst_fifo.sv
// rtl/rvc_asap_vga_burst_fifo.sv - synchronous prefetch FIFO of {last,data}, flushed by reset
module rvc_asap_vga_burst_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push_i & (~full_o | do_pop);

  assign wr_d    = wr_q + PW'(do_push);
  assign rd_d    = rd_q + PW'(do_pop);
  assign count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  assign rdata_o = mem_q[rd_q];

  `RVC_RST_MSFF(wr_q, wr_d, clk_i, rst_ni, '0)
  `RVC_RST_MSFF(rd_q, rd_d, clk_i, rst_ni, '0)
  `RVC_RST_MSFF(count_q, count_d, clk_i, rst_ni, '0)

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/rvc_asap_vga_burst_mem.sv
// rtl/rvc_asap_vga_burst_mem.sv - VGA frame-buffer memory: core port plus burst fetch engine
// Optional same-address core read/write forwarding: RVC_VGA_MEM_BYPASS_EN
module rvc_asap_vga_burst_mem
  import rvc_asap_pkg::*;
#(
  parameter int DATA_W     = VGA_BURST_DATA_W,
  parameter int ADDR_W     = VGA_BURST_ADDR_W,
  parameter int FIFO_DEPTH = VGA_BURST_FIFO_DEPTH,
  parameter int LEN_W      = VGA_BURST_LEN_W
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_byteen,
  input  logic                core_wren,
  input  logic                core_rden,
  output logic [DATA_W-1:0]   core_rdata,
  input  logic                vga_req_valid,
  output logic                vga_req_ready,
  input  logic [ADDR_W-1:0]   vga_req_addr,
  input  logic [LEN_W-1:0]    vga_req_len,
  output logic                vga_data_valid,
  input  logic                vga_data_ready,
  output logic [DATA_W-1:0]   vga_data,
  output logic                vga_data_last,
  output logic                vga_busy
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word, rdata_q, rdata_d;

  t_vga_burst_state  state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              push, pop, fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_wdata, fifo_rdata;

  always_ff @(posedge clock) begin
    if (core_wren) begin
      for (int i = 0; i < BE_W; i++) begin
        if (core_byteen[i]) mem[core_addr][8*i +: 8] <= core_wdata[8*i +: 8];
      end
    end
  end

`ifdef RVC_VGA_MEM_BYPASS_EN
  always_comb begin
    rd_word = mem[core_addr];
    for (int i = 0; i < BE_W; i++) begin
      if (core_wren && core_byteen[i]) rd_word[8*i +: 8] = core_wdata[8*i +: 8];
    end
  end
`else
  assign rd_word = mem[core_addr];
`endif

  assign rdata_d    = core_rden ? rd_word : rdata_q;
  assign core_rdata = rdata_q;
  `RVC_RST_MSFF(rdata_q, rdata_d, clock, rst_n, '0)

  assign pop        = vga_data_valid & vga_data_ready;
  // Fetch reads the array combinationally, so a same-cycle core write is seen next cycle only.
  assign fifo_wdata = {(cnt_q == '0), mem[addr_q]};

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    push          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vga_req_valid) begin
          addr_d  = vga_req_addr;
          cnt_d   = vga_req_len;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        push = ~fifo_full | pop;
        if (push) begin
          addr_d = addr_q + ADDR_W'(1);
          if (cnt_q == '0) state_d = S_DRAIN;
          else             cnt_d   = cnt_q - LEN_W'(1);
        end
      end
      S_DRAIN: begin
        if (fifo_empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  `RVC_RST_MSFF(state_q, state_d, clock, rst_n, S_IDLE)
  `RVC_MSFF(addr_q, addr_d, clock)
  `RVC_MSFF(cnt_q, cnt_d, clock)

  rvc_asap_vga_burst_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign vga_req_ready  = (state_q == S_IDLE);
  assign vga_busy       = (state_q != S_IDLE);
  assign vga_data_valid = ~fifo_empty;
  assign vga_data_last  = ~fifo_empty & fifo_rdata[DATA_W];
  assign vga_data       = fifo_rdata[DATA_W-1:0];
endmodule

// File: tb/tb_rvc_asap_vga_burst_mem.sv
// tb/tb_rvc_asap_vga_burst_mem.sv - directed scoreboard bench for rvc_asap_vga_burst_mem
module tb_rvc_asap_vga_burst_mem;
  logic        clock = 1'b0;
  logic        rst_n;
  logic [11:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_byteen;
  logic        core_wren, core_rden;
  logic [31:0] core_rdata;
  logic        vga_req_valid, vga_req_ready;
  logic [11:0] vga_req_addr;
  logic [7:0]  vga_req_len;
  logic        vga_data_valid, vga_data_ready;
  logic [31:0] vga_data;
  logic        vga_data_last, vga_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  logic [31:0] model [4096];
  logic [32:0] sb [$];

  always #5 clock = ~clock;

  rvc_asap_vga_burst_mem dut (
    .clock(clock), .rst_n(rst_n),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_byteen(core_byteen),
    .core_wren(core_wren), .core_rden(core_rden), .core_rdata(core_rdata),
    .vga_req_valid(vga_req_valid), .vga_req_ready(vga_req_ready),
    .vga_req_addr(vga_req_addr), .vga_req_len(vga_req_len),
    .vga_data_valid(vga_data_valid), .vga_data_ready(vga_data_ready),
    .vga_data(vga_data), .vga_data_last(vga_data_last), .vga_busy(vga_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic core_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    core_addr = a; core_wdata = d; core_byteen = be; core_wren = 1'b1;
    tick();
    core_wren = 1'b0;
    for (int i = 0; i < 4; i++) if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic core_read(input logic [11:0] a, output logic [31:0] d);
    core_addr = a; core_rden = 1'b1;
    tick();
    core_rden = 1'b0;
    d = core_rdata;
  endtask

  task automatic burst(input logic [11:0] a, input logic [7:0] len);
    logic [11:0] p;
    p = a;
    for (int i = 0; i <= int'(len); i++) begin
      sb.push_back({(i == int'(len)), model[p]});
      p = p + 12'd1;
    end
    vga_req_addr = a; vga_req_len = len; vga_req_valid = 1'b1;
    tick();
    vga_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (vga_busy && k < 200) begin
      tick();
      k++;
    end
    check("idle_timeout", vga_busy, 0);
  endtask

  // Handshakes are sampled mid-cycle, before the edge that completes them.
  always @(negedge clock) begin
    if (rst_n && vga_data_valid && vga_data_ready) begin
      n_pops++;
      if (sb.size() == 0) begin
        check("sb_unexpected_pop", 1, 0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("vga_data", vga_data, e[31:0]);
        check("vga_last", vga_data_last, e[32]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int p0;
    rst_n = 1'b0; core_addr = '0; core_wdata = '0; core_byteen = '0;
    core_wren = 1'b0; core_rden = 1'b0; vga_req_valid = 1'b0;
    vga_req_addr = '0; vga_req_len = '0; vga_data_ready = 1'b0;
    tick(); tick();
    check("rst_rdata", core_rdata, 0);
    check("rst_valid", vga_data_valid, 0);
    check("rst_last", vga_data_last, 0);
    check("rst_busy", vga_busy, 0);
    check("rst_req_ready", vga_req_ready, 1);
    rst_n = 1'b1;

    // 1-2: full and partial byte-enable writes, read hold
    core_write(12'h010, 32'hA5A5A5A5, 4'b1111);
    core_read(12'h010, rd);
    check("rd_full_word", rd, 32'hA5A5A5A5);
    core_write(12'h010, 32'h11223344, 4'b0101);
    core_read(12'h010, rd);
    check("rd_byteen", rd, 32'hA522A544);
    core_addr = 12'h000;
    tick(); tick();
    check("rd_hold", core_rdata, 32'hA522A544);

    // 3: wrapping burst with immediate drain
    core_write(12'hFFE, 32'h0000_0FFE, 4'b1111);
    core_write(12'hFFF, 32'h0000_0FFF, 4'b1111);
    core_write(12'h000, 32'hC0DE_0000, 4'b1111);
    core_write(12'h001, 32'hC0DE_0001, 4'b1111);
    for (int i = 0; i < 8; i++) core_write(12'h020 + 12'(i), 32'h5000_0000 + 32'(i * 3), 4'b1111);
    vga_data_ready = 1'b1;
    p0 = n_pops;
    check("req_ready_idle", vga_req_ready, 1);
    burst(12'hFFE, 8'd3);
    check("lat_t1_valid", vga_data_valid, 0);
    check("lat_t1_busy", vga_busy, 1);
    check("lat_t1_req_ready", vga_req_ready, 0);
    tick();
    check("lat_t2_valid", vga_data_valid, 1);
    wait_idle();
    tick();
    check("burst3_pops", n_pops - p0, 4);
    check("burst3_sb_empty", sb.size(), 0);
    check("burst3_req_ready", vga_req_ready, 1);

    // 4: back-pressure for 10 cycles
    vga_data_ready = 1'b0;
    p0 = n_pops;
    burst(12'h020, 8'd7);
    tick(); tick();
    check("bp_head_first", vga_data, model[12'h020]);
    for (int i = 0; i < 8; i++) tick();
    check("bp_head_stable", vga_data, model[12'h020]);
    check("bp_head_last", vga_data_last, 0);
    check("bp_occupancy", dut.u_fifo.count_q, 4);
    check("bp_busy", vga_busy, 1);
    vga_data_ready = 1'b1;
    wait_idle();
    tick();
    check("burst8_pops", n_pops - p0, 8);
    check("burst8_sb_empty", sb.size(), 0);

    // 5: same-address read+write
    core_write(12'h000, 32'h0, 4'b1111);
    core_addr = 12'h000; core_wdata = 32'hDEADBEEF; core_byteen = 4'b1111;
    core_wren = 1'b1; core_rden = 1'b1;
    tick();
    core_wren = 1'b0; core_rden = 1'b0;
    model[12'h000] = 32'hDEADBEEF;
`ifdef RVC_VGA_MEM_BYPASS_EN
    check("rw_same_addr", core_rdata, 32'hDEADBEEF);
`else
    check("rw_same_addr", core_rdata, 32'h0);
`endif
    core_read(12'h000, rd);
    check("rw_after", rd, 32'hDEADBEEF);

    // 6: reset mid-burst
    vga_data_ready = 1'b0;
    burst(12'h020, 8'd7);
    for (int i = 0; i < 3; i++) tick();
    check("mid_busy", vga_busy, 1);
    rst_n = 1'b0;
    tick();
    sb.delete();
    check("mrst_valid", vga_data_valid, 0);
    check("mrst_busy", vga_busy, 0);
    check("mrst_req_ready", vga_req_ready, 1);
    check("mrst_rdata", core_rdata, 0);
    rst_n = 1'b1;
    vga_data_ready = 1'b1;
    tick();
    check("post_rst_valid", vga_data_valid, 0);
    core_read(12'h010, rd);
    check("mem_kept_010", rd, model[12'h010]);
    core_read(12'h023, rd);
    check("mem_kept_023", rd, model[12'h023]);

    // fresh burst after reset still works
    p0 = n_pops;
    burst(12'h000, 8'd1);
    wait_idle();
    tick();
    check("post_rst_pops", n_pops - p0, 2);
    check("post_rst_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
